// File: rtl/re_mapper_gen.sv
// Resource-element mapper: walks one slot's allocated subcarriers symbol by symbol and
// writes DMRS (comb pattern, zero-filled gaps) or data samples to the grid.
module re_mapper_gen #(
    parameter int DW     = 18,
    parameter int DMRS_W = 9,
    parameter int NSC    = 1200,
    parameter int AW     = 11,
    parameter int NSYM   = 14
) (
    input  logic                     CLK_RE,
    input  logic                     RST_RE,
    input  logic                     start,
    input  logic                     abort,
    input  logic [AW-1:0]            sc_start,
    input  logic [6:0]               n_rb,
    input  logic [3:0]               sym_start,
    input  logic [3:0]               sym_end,
    input  logic [NSYM-1:0]          dmrs_mask,
    input  logic                     comb_off,
    input  logic signed [DMRS_W-1:0] dmrs_i,
    input  logic signed [DMRS_W-1:0] dmrs_q,
    input  logic                     dmrs_valid,
    output logic                     dmrs_ready,
    input  logic signed [DW-1:0]     dat_i,
    input  logic signed [DW-1:0]     dat_q,
    input  logic                     dat_valid,
    output logic                     dat_ready,
    output logic                     wr_en,
    output logic [AW-1:0]            wr_addr,
    output logic [3:0]               wr_sym,
    output logic signed [DW-1:0]     re_i,
    output logic signed [DW-1:0]     re_q,
    output logic                     sym_done,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MAP_DMRS, S_MAP_DATA, S_DONE} state_t;

    function automatic logic signed [DW-1:0] sext_dmrs(input logic signed [DMRS_W-1:0] v);
        return {{(DW-DMRS_W){v[DMRS_W-1]}}, v};
    endfunction

    state_t                 state_q, state_d;
    logic [AW-1:0]          sc_start_q, sc_start_d;
    logic [6:0]             n_rb_q, n_rb_d;
    logic [3:0]             sym_start_q, sym_start_d;
    logic [3:0]             sym_end_q, sym_end_d;
    logic [NSYM-1:0]        mask_q, mask_d;
    logic                   comb_q, comb_d;
    logic [AW-1:0]          k_q, k_d;
    logic [3:0]             sym_q, sym_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   wr_en_q, wr_en_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic [3:0]             wr_sym_q, wr_sym_d;
    logic signed [DW-1:0]   re_i_q, re_i_d;
    logic signed [DW-1:0]   re_q_q, re_q_d;
    logic                   sym_done_q, sym_done_d;
    logic                   done_q, done_d;

    logic [AW-1:0]          n_len;
    logic [AW:0]            sc_end;
    logic                   bad_cfg;
    logic                   last_k;
    logic                   pilot;
    logic                   adv;
    logic [3:0]             nxt_sym;

    always_comb begin
        state_d     = state_q;
        sc_start_d  = sc_start_q;
        n_rb_d      = n_rb_q;
        sym_start_d = sym_start_q;
        sym_end_d   = sym_end_q;
        mask_d      = mask_q;
        comb_d      = comb_q;
        k_d         = k_q;
        sym_d       = sym_q;
        cfg_err_d   = cfg_err_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_sym_d    = wr_sym_q;
        re_i_d      = re_i_q;
        re_q_d      = re_q_q;
        sym_done_d  = 1'b0;
        done_d      = 1'b0;
        dmrs_ready  = 1'b0;
        dat_ready   = 1'b0;
        busy        = 1'b0;
        adv         = 1'b0;

        // N = 12*n_rb; end-of-allocation compared one bit wider than the address
        n_len   = AW'({n_rb_q, 3'b000}) + AW'({n_rb_q, 2'b00});
        sc_end  = {1'b0, sc_start_q} + {1'b0, n_len};
        bad_cfg = (n_rb_q == 7'd0) || (sc_end > (AW+1)'(NSC)) ||
                  (sym_end_q < sym_start_q) || ({1'b0, sym_end_q} >= 5'(NSYM));
        last_k  = (k_q == n_len - AW'(1));
        pilot   = (k_q[0] == comb_q);
        nxt_sym = sym_q + 4'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sc_start_d  = sc_start;
                    n_rb_d      = n_rb;
                    sym_start_d = sym_start;
                    sym_end_d   = sym_end;
                    mask_d      = dmrs_mask;
                    comb_d      = comb_off;
                    cfg_err_d   = 1'b0;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                busy  = 1'b1;
                k_d   = '0;
                sym_d = sym_start_q;
                if (bad_cfg) begin
                    cfg_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = mask_q[sym_start_q] ? S_MAP_DMRS : S_MAP_DATA;
                end
            end
            S_MAP_DMRS, S_MAP_DATA: begin
                busy = 1'b1;
                if (state_q == S_MAP_DMRS) begin
                    // gap positions write zero and never wait on the DMRS stream
                    adv        = pilot ? dmrs_valid : 1'b1;
                    dmrs_ready = pilot && dmrs_valid;
                    re_i_d     = pilot ? sext_dmrs(dmrs_i) : '0;
                    re_q_d     = pilot ? sext_dmrs(dmrs_q) : '0;
                end else begin
                    adv       = dat_valid;
                    dat_ready = dat_valid;
                    re_i_d    = dat_i;
                    re_q_d    = dat_q;
                end
                if (adv) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = sc_start_q + k_q;
                    wr_sym_d  = sym_q;
                    if (last_k) begin
                        sym_done_d = 1'b1;
                        k_d        = '0;
                        if (sym_q == sym_end_q) begin
                            state_d = S_DONE;
                        end else begin
                            sym_d   = nxt_sym;
                            state_d = mask_q[nxt_sym] ? S_MAP_DMRS : S_MAP_DATA;
                        end
                    end else begin
                        k_d = k_q + AW'(1);
                    end
                end else begin
                    re_i_d = re_i_q;
                    re_q_d = re_q_q;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // cancel overrides everything decided above, including a start in IDLE
        if (abort) begin
            state_d    = S_IDLE;
            k_d        = '0;
            cfg_err_d  = cfg_err_q;
            wr_en_d    = 1'b0;
            re_i_d     = re_i_q;
            re_q_d     = re_q_q;
            wr_addr_d  = wr_addr_q;
            wr_sym_d   = wr_sym_q;
            sym_done_d = 1'b0;
            done_d     = 1'b0;
            dmrs_ready = 1'b0;
            dat_ready  = 1'b0;
        end
    end

    always_ff @(posedge CLK_RE or negedge RST_RE) begin
        if (!RST_RE) begin
            state_q     <= S_IDLE;
            sc_start_q  <= '0;
            n_rb_q      <= '0;
            sym_start_q <= '0;
            sym_end_q   <= '0;
            mask_q      <= '0;
            comb_q      <= 1'b0;
            k_q         <= '0;
            sym_q       <= '0;
            cfg_err_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_sym_q    <= '0;
            re_i_q      <= '0;
            re_q_q      <= '0;
            sym_done_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sc_start_q  <= sc_start_d;
            n_rb_q      <= n_rb_d;
            sym_start_q <= sym_start_d;
            sym_end_q   <= sym_end_d;
            mask_q      <= mask_d;
            comb_q      <= comb_d;
            k_q         <= k_d;
            sym_q       <= sym_d;
            cfg_err_q   <= cfg_err_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_sym_q    <= wr_sym_d;
            re_i_q      <= re_i_d;
            re_q_q      <= re_q_d;
            sym_done_q  <= sym_done_d;
            done_q      <= done_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_sym   = wr_sym_q;
    assign re_i     = re_i_q;
    assign re_q     = re_q_q;
    assign sym_done = sym_done_q;
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;

endmodule
